axis_ad5791_rx: RTL

AXIS_AD5791_RX -- requirements
Module: axis_ad5791_rx

---
 rtl/ad5791_pkg.sv | 22 ++
 rtl/ad5791_rx_sync.sv | 26 ++
 rtl/axis_ad5791_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ad5791_pkg.sv
// Shared constants and types for the AD5791 SPI-to-AXI-Stream receiver.
package ad5791_pkg;

  localparam int unsigned DAC_DATA_WIDTH = 20;
  localparam int unsigned DAC_WORD_WIDTH = 24;
  localparam int unsigned DAC_ADDR_WIDTH = 4;

  // Register address the transmitter places in bits [23:20] of a DAC write
  localparam logic [DAC_ADDR_WIDTH-1:0] DAC_REG_ADDR = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // True when an address nibble selects the DAC data register
  function automatic logic is_dac_reg(input logic [DAC_ADDR_WIDTH-1:0] addr);
    return addr == DAC_REG_ADDR;
  endfunction

endpackage

// File: rtl/ad5791_rx_sync.sv
// Two-flop synchronizer plus one history flop for edge detection on one line.
module ad5791_rx_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic edge_c
);

  logic [2:0] pipe;

  // pipe[1] is the synchronized level, pipe[2] the level one cycle earlier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= {3{RESET_VAL}};
    end else begin
      pipe <= {pipe[1:0], d};
    end
  end

  assign q      = pipe[1];
  assign edge_c = pipe[1] ^ pipe[2];

endmodule

// File: rtl/axis_ad5791_rx.sv
// AD5791 SPI frame receiver: deserializes NUM_DAC parallel lanes and emits
// each accepted frame as one AXI-Stream beat (no back-pressure).
// Optional build macro AXIS_AD5791_RX_STATS_EN adds frame/error counters.
module axis_ad5791_rx #(
  parameter int unsigned NUM_DAC           = 4,
  parameter int unsigned DAC_DATA_WIDTH    = ad5791_pkg::DAC_DATA_WIDTH,
  parameter int unsigned DAC_WORD_WIDTH    = ad5791_pkg::DAC_WORD_WIDTH,
  parameter int unsigned MAXIS_TDATA_WIDTH = 32
) (
  input  logic                                 a_clk,
  input  logic                                 a_rst,
  input  logic                                 wire_PMD_clk,
  input  logic                                 wire_PMD_sync,
  input  logic [NUM_DAC-1:0]                   wire_PMD_dac,
  output logic [NUM_DAC*MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                                 M_AXIS_tvalid,
  output logic [NUM_DAC*4-1:0]                 M_AXIS_taddr,
  output logic                                 frame_error
`ifdef AXIS_AD5791_RX_STATS_EN
  ,
  output logic [15:0]                          frame_count,
  output logic [15:0]                          error_count
`endif
);

  import ad5791_pkg::*;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned PAD_W = MAXIS_TDATA_WIDTH - DAC_DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DAC_WORD_WIDTH);

  logic               sclk_q, sclk_edge_c;
  logic               sync_q, sync_edge_c;
  logic [NUM_DAC-1:0] lane_q;
  logic [NUM_DAC-1:0] lane_edge_c_unused;

  logic sclk_fall_c, sync_fall_c, sync_rise_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_DAC-1:0][DAC_WORD_WIDTH-1:0] sr_q, sr_d;

  logic                                       tvalid_d, ferr_d;
  logic [NUM_DAC-1:0][MAXIS_TDATA_WIDTH-1:0]  tdata_d;
  logic [NUM_DAC-1:0][3:0]                    taddr_d;

  logic [1:0] flush_q;
  logic       armed_q;

  ad5791_rx_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(a_clk), .rst(a_rst), .d(wire_PMD_clk), .q(sclk_q), .edge_c(sclk_edge_c)
  );

  ad5791_rx_sync #(.RESET_VAL(1'b1)) u_sync_sync (
    .clk(a_clk), .rst(a_rst), .d(wire_PMD_sync), .q(sync_q), .edge_c(sync_edge_c)
  );

  for (genvar i = 0; i < NUM_DAC; i++) begin : g_lane
    ad5791_rx_sync #(.RESET_VAL(1'b0)) u_sync_dac (
      .clk(a_clk), .rst(a_rst), .d(wire_PMD_dac[i]), .q(lane_q[i]),
      .edge_c(lane_edge_c_unused[i])
    );
  end

  assign sclk_fall_c = sclk_edge_c & ~sclk_q;
  assign sync_fall_c = sync_edge_c & ~sync_q;
  assign sync_rise_c = sync_edge_c &  sync_q;

  // Arm only after SYNC has been seen high with real (post-reset) samples,
  // so a frame already in progress at reset release is never captured
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      if (flush_q != 2'd2) flush_q <= flush_q + 2'd1;
      if (flush_q == 2'd2 && sync_q) armed_q <= 1'b1;
    end
  end

  // Next-state, deserializer and output decode; the accept/reject decision is
  // taken on the way into CHECK so the pulse coincides with the CHECK cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    tvalid_d = 1'b0;
    ferr_d   = 1'b0;
    tdata_d  = M_AXIS_tdata;
    taddr_d  = M_AXIS_taddr;

    case (state_q)
      ST_IDLE: begin
        if (sync_fall_c && armed_q) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      ST_SHIFT: begin
        if (sclk_fall_c) begin
          for (int unsigned i = 0; i < NUM_DAC; i++) begin
            sr_d[i] = {sr_q[i][DAC_WORD_WIDTH-2:0], lane_q[i]};
          end
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
        if (sync_rise_c) begin
          state_d = ST_CHECK;
          if (cnt_d == CNT_FULL) begin
            tvalid_d = 1'b1;
            for (int unsigned i = 0; i < NUM_DAC; i++) begin
              tdata_d[i] = {sr_d[i][DAC_DATA_WIDTH-1:0], {PAD_W{1'b0}}};
              taddr_d[i] = sr_d[i][DAC_DATA_WIDTH +: 4];
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state, bit counter and shift registers
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Registered stream outputs; tdata/taddr hold between frames
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      M_AXIS_tdata  <= '0;
      M_AXIS_taddr  <= '0;
      M_AXIS_tvalid <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      M_AXIS_tdata  <= tdata_d;
      M_AXIS_taddr  <= taddr_d;
      M_AXIS_tvalid <= tvalid_d;
      frame_error   <= ferr_d;
    end
  end

`ifdef AXIS_AD5791_RX_STATS_EN
  // Accepted/rejected frame counters, wrapping at 16 bits
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (tvalid_d) frame_count <= frame_count + 16'd1;
      if (ferr_d)   error_count <= error_count + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
